// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int FETCH_N         = 32;
  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    SKID,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_N-1:0] pc;
    logic [FETCH_N-1:0] instr;
    logic [FETCH_N-1:0] pc_plus4;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding register for a fetch bundle
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   load         capture load_data (ignored while clear or unload)
//   load_data    bundle to capture
//   unload       entry consumed downstream, empties the buffer
//   clear        discard the entry (redirect)
//   full         entry present
//   data         stored bundle
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  fetch_bundle_t load_data,
  input  logic          unload,
  input  logic          clear,
  output logic          full,
  output fetch_bundle_t data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage with PC, one-outstanding imem requests and skid buffer
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-low reset
//   stall                         downstream not consuming this cycle
//   branch_taken, branch_target   redirect from EX (one-cycle pulse)
//   imem_req, imem_addr           fetch request (addr is the current pc)
//   imem_ready                    request accepted when imem_req & imem_ready
//   imem_rvalid, imem_rdata       one-cycle read response
//   if_valid, if_pc, if_instr,
//   if_pc_plus4                   bundle presented to the IF/ID register
//   perf_fetched,
//   perf_stall_cycles             saturating counters, only with FETCH_PERF_EN
//
// Build option: define FETCH_PERF_EN to add the performance counter ports.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
  parameter int           PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         if_valid,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] if_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall_cycles
`endif
);

  fetch_state_t  state;
  logic [N-1:0]  pc;
  logic [N-1:0]  pc_next_seq;
  logic          consume;
  logic          out_free;
  logic          rsp_take;
  logic          rsp_skid;
  logic          skid_unload;
  logic          skid_full;
  fetch_bundle_t rsp_bundle;
  fetch_bundle_t skid_data;

  // Sequential PC wraps modulo 2^N; if_pc_plus4 reuses the same sum.
  assign pc_next_seq = pc + N'(PC_STEP);

  assign consume  = if_valid & ~stall;
  assign out_free = ~if_valid | consume;

  // A redirect in the same cycle drops the response outright.
  assign rsp_take    = (state == WAIT) & imem_rvalid & ~branch_taken & out_free;
  assign rsp_skid    = (state == WAIT) & imem_rvalid & ~branch_taken & ~out_free;
  assign skid_unload = skid_full & consume & ~branch_taken;

  assign rsp_bundle = '{pc: pc, instr: imem_rdata, pc_plus4: pc_next_seq};

  // Only REQ drives a request, and REQ is never entered with the skid occupied.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (rsp_skid),
    .load_data (rsp_bundle),
    .unload    (skid_unload),
    .clear     (branch_taken),
    .full      (skid_full),
    .data      (skid_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
    end else begin
      // Output register: redirect > new load > consume.
      if (branch_taken) begin
        if_valid <= 1'b0;
      end else if (rsp_take) begin
        if_valid    <= 1'b1;
        if_pc       <= rsp_bundle.pc;
        if_instr    <= rsp_bundle.instr;
        if_pc_plus4 <= rsp_bundle.pc_plus4;
      end else if (skid_unload) begin
        if_valid    <= 1'b1;
        if_pc       <= skid_data.pc;
        if_instr    <= skid_data.instr;
        if_pc_plus4 <= skid_data.pc_plus4;
      end else if (consume) begin
        if_valid <= 1'b0;
      end

      if (branch_taken) begin
        pc <= branch_target;
      end else if (rsp_take || rsp_skid) begin
        pc <= pc_next_seq;
      end

      case (state)
        BOOT: state <= REQ;
        REQ: begin
          // An accepted old-PC request still owes a response; drain it.
          if (imem_ready) state <= branch_taken ? DRAIN : WAIT;
        end
        WAIT: begin
          if (branch_taken)  state <= imem_rvalid ? REQ : DRAIN;
          else if (rsp_take) state <= REQ;
          else if (rsp_skid) state <= SKID;
        end
        SKID: begin
          if (branch_taken || skid_unload) state <= REQ;
        end
        DRAIN: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (consume && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (if_valid && stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr, if_pc_plus4;
  logic        req_b, v_b;
  logic [31:0] addr_b, pc_b, instr_b, p4_b;
`ifdef FETCH_PERF_EN
  logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  auto_mem = 1'b1;
  bit  use_b = 1'b0;
  bit  pend = 1'b0;
  logic [31:0] pend_addr = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_a), .perf_stall_cycles(ps_a)
`endif
  );

  fetch_stage #(.N(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_b (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(v_b), .if_pc(pc_b), .if_instr(instr_b), .if_pc_plus4(p4_b)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_b), .perf_stall_cycles(ps_b)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0000_0000: word = 32'h00A0_0093;
      32'h0000_0004: word = 32'h00B0_0113;
      default:       word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Advance to the next falling edge; in auto mode answer each accepted
  // request exactly one cycle after its handshake.
  task automatic cyc();
    @(negedge clk);
    if (auto_mem) begin
      imem_rvalid = pend;
      imem_rdata  = word(pend_addr);
      pend        = (use_b ? req_b : imem_req) & imem_ready;
      pend_addr   = use_b ? addr_b : imem_addr;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_rvalid = 1'b0;
    imem_ready = 1'b1;
    auto_mem = 1'b1;
    pend = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({imem_req, if_valid, if_pc, if_instr, if_pc_plus4, imem_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: req=%b v=%b pc=%h instr=%h p4=%h addr=%h want all 0",
               imem_req, if_valid, if_pc, if_instr, if_pc_plus4, imem_addr);
    end
    n_cmp++;
    if (req_b !== 1'b0 || v_b !== 1'b0 || addr_b !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL reset_b: req=%b v=%b addr=%h want 0 0 fffffffc", req_b, v_b, addr_b);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (c % 2 == 1) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(2 * (c - 1))) begin
          n_bad++;
          $display("FAIL seq_req c%0d: req=%b addr=%h want 1 %h", c, imem_req, imem_addr, 32'(2 * (c - 1)));
        end
        if (c >= 3) begin
          n_cmp++;
          if (if_valid !== 1'b1 || if_pc !== 32'(2 * (c - 3)) ||
              if_pc_plus4 !== 32'(2 * (c - 3) + 4) || if_instr !== word(32'(2 * (c - 3)))) begin
            n_bad++;
            $display("FAIL seq_out c%0d: v=%b pc=%h p4=%h instr=%h want 1 %h %h %h", c, if_valid,
                     if_pc, if_pc_plus4, if_instr, 32'(2 * (c - 3)), 32'(2 * (c - 3) + 4),
                     word(32'(2 * (c - 3))));
          end
        end
      end else begin
        n_cmp++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL seq_idle c%0d: req=%b v=%b want 0 0", c, imem_req, if_valid);
        end
      end
    end
  endtask

  task automatic test_skid();
    do_reset();
    repeat (3) cyc();
    n_cmp++;
    if (if_valid !== 1'b1 || if_instr !== 32'h00A0_0093) begin
      n_bad++;
      $display("FAIL skid_first: v=%b instr=%h want 1 00a00093", if_valid, if_instr);
    end
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_cmp++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_instr !== 32'h00A0_0093) begin
        n_bad++;
        $display("FAIL skid_hold k%0d: req=%b v=%b instr=%h want 0 1 00a00093", k, imem_req, if_valid, if_instr);
      end
    end
    stall = 1'b0;
    cyc();
    n_cmp++;
    if (if_valid !== 1'b1 || if_instr !== 32'h00B0_0113 || if_pc !== 32'h4 ||
        imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_bad++;
      $display("FAIL skid_release: v=%b instr=%h pc=%h req=%b addr=%h want 1 00b00113 4 1 8",
               if_valid, if_instr, if_pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_rvalid();
    do_reset();
    repeat (2) cyc();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    cyc();
    branch_taken = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL br_rvalid: v=%b req=%b addr=%h want 0 1 100", if_valid, imem_req, imem_addr);
    end
    repeat (2) cyc();
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== word(32'h100)) begin
      n_bad++;
      $display("FAIL br_rvalid_next: v=%b pc=%h instr=%h want 1 100 %h", if_valid, if_pc, if_instr, word(32'h100));
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    cyc();
    auto_mem = 1'b0;
    cyc();
    branch_taken = 1'b1;
    branch_target = 32'h200;
    cyc();
    branch_taken = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL br_wait_drain: req=%b v=%b want 0 0", imem_req, if_valid);
    end
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL br_wait_req: req=%b addr=%h v=%b want 1 200 0", imem_req, imem_addr, if_valid);
    end
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL br_wait_out: v=%b pc=%h instr=%h want 1 200 12345678", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap();
    use_b = 1'b1;
    do_reset();
    cyc();
    n_cmp++;
    if (req_b !== 1'b1 || addr_b !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_req0: req=%b addr=%h want 1 fffffffc", req_b, addr_b);
    end
    repeat (2) cyc();
    n_cmp++;
    if (v_b !== 1'b1 || pc_b !== 32'hFFFF_FFFC || p4_b !== 32'h0 ||
        instr_b !== word(32'hFFFF_FFFC) || addr_b !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_first: v=%b pc=%h p4=%h instr=%h addr=%h want 1 fffffffc 0 %h 0",
               v_b, pc_b, p4_b, instr_b, addr_b, word(32'hFFFF_FFFC));
    end
    repeat (2) cyc();
    n_cmp++;
    if (v_b !== 1'b1 || pc_b !== 32'h0 || p4_b !== 32'h4) begin
      n_bad++;
      $display("FAIL wrap_second: v=%b pc=%h p4=%h want 1 0 4", v_b, pc_b, p4_b);
    end
    use_b = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    repeat (3) cyc();
    stall = 1'b1;
    cyc();
    #2 reset = 1'b0;
    auto_mem = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req, if_valid, if_pc, if_instr, if_pc_plus4, imem_addr} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: req=%b v=%b pc=%h instr=%h p4=%h addr=%h want all 0",
               imem_req, if_valid, if_pc, if_instr, if_pc_plus4, imem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBADB_AD00;
    cyc();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_first_req: req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, if_valid);
    end
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata = word(32'h0);
    cyc();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== word(32'h0)) begin
      n_bad++;
      $display("FAIL rst_late_rvalid: v=%b pc=%h instr=%h want 1 0 %h", if_valid, if_pc, if_instr, word(32'h0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_skid();
    test_branch_rvalid();
    test_branch_wait();
    test_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage. Owns the PC, issues one-outstanding requests to instruction memory, and presents {pc, instr, pc_plus4} with a valid flag to the IF/ID pipeline register. Stall comes from the hazard unit, which also drives the IF/ID enable. A one-entry skid buffer keeps a response that arrives during a stall. Branch redirects come from EX and discard wrong-path fetches.

Parameters:
N, 32, data/address width
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low
stall  in  1  downstream not consuming this cycle
branch_taken  in  1  redirect request from EX, one-cycle pulse
branch_target  in  N  redirect PC
imem_req  out  1  fetch request valid
imem_addr  out  N  fetch address, equals current PC
imem_ready  in  1  memory accepts request (req & ready = handshake)
imem_rvalid  in  1  read data valid, one cycle
imem_rdata  in  N  instruction word
if_valid  out  1  output bundle valid
if_pc  out  N  PC of presented instruction
if_instr  out  N  presented instruction
if_pc_plus4  out  N  if_pc + PC_STEP

Behaviour:
- Reset (async, reset=0): pc=RESET_PC, state=BOOT, skid empty. imem_req=0, if_valid=0, if_pc/if_instr/if_pc_plus4=0. Effect is immediate; an in-flight memory response is forgotten.
- consume = if_valid & !stall, sampled at a rising edge. On consume with no new load, if_valid clears.
- States:
  - BOOT: one cycle with imem_req=0, then REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready go to WAIT. Requests are only issued when the skid buffer is empty.
  - WAIT: imem_req=0.
    - On imem_rvalid with the output free (!if_valid or consume): load the output registers. if_valid=1 on the next edge. pc += PC_STEP. Go to REQ.
    - On imem_rvalid with the output occupied and stall=1: write the skid buffer. pc += PC_STEP. Go to SKID.
  - SKID: imem_req=0. On consume, the output registers take the skid contents, the skid empties, and the stage goes to REQ.
  - DRAIN: imem_req=0. Discard the next imem_rvalid, then go to REQ.
- Latency: imem_rvalid at edge k makes if_valid=1 after edge k. Back-to-back throughput is one instruction per 2 cycles plus memory latency.
- Redirect: branch_taken has priority over every other event in the same cycle.
  - pc <= branch_target.
  - if_valid cleared and skid emptied on that edge.
  - In REQ without imem_ready: stay in REQ with the new pc.
  - In REQ with imem_ready in the same cycle: go to DRAIN, because the old-PC request was accepted.
  - In WAIT: an imem_rvalid in the same cycle is dropped and the stage goes to REQ. Without imem_rvalid, go to DRAIN.
  - In SKID or BOOT: go to REQ.
- PC arithmetic is modulo 2^N and wraps silently. if_pc_plus4 is computed from the same wrap.
- imem_rvalid in BOOT or REQ is a protocol error. It is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: add output ports perf_fetched [31:0] and perf_stall_cycles [31:0].
  - perf_fetched increments on each consume.
  - perf_stall_cycles increments each cycle with if_valid & stall.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {BOOT, REQ, WAIT, SKID, DRAIN}
  - typedef fetch_bundle_t {pc, instr, pc_plus4}
  - constant PC_STEP_DEFAULT
- One sub-module, fetch_skid_buffer: a one-entry buffer of fetch_bundle_t with load/unload/clear and async active-low reset.

Test Plan:
- Reset release, imem_ready=1, 1-cycle memory latency, stall=0 -> requests to addresses 0x0, 0x4, 0x8. if_pc sequence 0x0/0x4/0x8 with if_pc_plus4 = 0x4/0x8/0xC. if_valid=1 one cycle after each rvalid.
- stall=1 held for 5 cycles while instr 0x00A00093 is presented and the next response 0x00B00113 arrives -> the second word goes to the skid, imem_req stays 0, and if_instr holds 0x00A00093. Release stall -> 0x00B00113 is presented next cycle, and the next request is to pc+8.
- branch_taken with target 0x100 in the same cycle as imem_rvalid -> the response is dropped, if_valid=0, and the next imem_addr=0x100.
- branch_taken with target 0x200 in WAIT, rvalid arriving 2 cycles later -> that data is never presented, and the next request is to 0x200.
- RESET_PC=32'hFFFF_FFFC -> second fetch address is 0x0 and if_pc_plus4 of the first instruction is 0x0.
- reset asserted mid-WAIT -> all outputs are 0 immediately. After release the first request is to RESET_PC one cycle later, and a late rvalid is ignored.
